// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the mem_dump readback engine.
// MEM_DUMP_CHECKSUM_EN adds the CSUM state for the trailing checksum beat.
package mem_dump_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
`ifdef MEM_DUMP_CHECKSUM_EN
    ST_DONE = 3'd4,
    ST_CSUM = 3'd5
`else
    ST_DONE = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/mem_dump.sv
// RAM readback engine: reads a word range and streams (address, data) beats.
// Define MEM_DUMP_CHECKSUM_EN to append a 32-bit running-sum beat after the data.
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   sysClk,
  input  logic                   sysRes,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  baseAddr,
  input  logic [COUNT_WIDTH-1:0] wordCount,
  output logic [ADDR_WIDTH-1:0]  memAddr,
  output logic                   memRe,
  input  logic [DATA_WIDTH-1:0]  memRdata,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [DATA_WIDTH-1:0]  outData,
  output logic [ADDR_WIDTH-1:0]  outAddr,
  output logic                   outLast,
  output logic                   busy,
  output logic                   done,
  output state_t                 fsm_state
);

  // Stream handshake: a beat transfers on any rising edge where outValid and
  // outReady are both 1; once raised, outValid and its payload hold until then.

  localparam logic [ADDR_WIDTH-1:0]  STEP      = ADDR_WIDTH'(WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0]  ALIGN     = ~ADDR_WIDTH'(WORD_BYTES - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE_WORD  = COUNT_WIDTH'(1);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   handshake;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]  sum;
`endif

  assign handshake = outValid & outReady;
  assign fsm_state = state;

  always_ff @(posedge sysClk) begin
    if (!sysRes) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      memAddr   <= '0;
      memRe     <= 1'b0;
      outValid  <= 1'b0;
      outData   <= '0;
      outAddr   <= '0;
      outLast   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            addr      <= baseAddr & ALIGN;
            remaining <= wordCount;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum       <= '0;
`endif
            if (wordCount != '0) begin
              state   <= ST_READ;
              memRe   <= 1'b1;
              memAddr <= baseAddr & ALIGN;
            end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
              // Empty dump still reports a checksum of zero.
              state    <= ST_CSUM;
              outValid <= 1'b1;
              outData  <= '0;
              outAddr  <= baseAddr & ALIGN;
              outLast  <= 1'b1;
`else
              state <= ST_DONE;
              done  <= 1'b1;
`endif
            end
          end
        end

        ST_READ: begin
          memRe <= 1'b0;
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          outData  <= memRdata;
          outAddr  <= addr;
          outValid <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
          outLast  <= 1'b0;
`else
          outLast  <= (remaining == ONE_WORD);
`endif
          state    <= ST_SEND;
        end

        ST_SEND: begin
          if (handshake) begin
            outValid  <= 1'b0;
            outLast   <= 1'b0;
            addr      <= addr + STEP;
            remaining <= remaining - ONE_WORD;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum       <= sum + outData;
`endif
            if (remaining != ONE_WORD) begin
              state   <= ST_READ;
              memRe   <= 1'b1;
              memAddr <= addr + STEP;
            end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
              state    <= ST_CSUM;
              outValid <= 1'b1;
              outData  <= sum + outData;
              outAddr  <= addr + STEP;
              outLast  <= 1'b1;
`else
              state <= ST_DONE;
              done  <= 1'b1;
`endif
            end
          end
        end

`ifdef MEM_DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (handshake) begin
            outValid <= 1'b0;
            outLast  <= 1'b0;
            state    <= ST_DONE;
            done     <= 1'b1;
          end
        end
`endif

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump.sv
// Scoreboard bench for mem_dump: directed dumps, stall, zero count, wrap, reset abort.
// Build with MEM_DUMP_CHECKSUM_EN defined to expect the trailing checksum beat.
module tb_mem_dump;
  import mem_dump_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        sysClk = 1'b0;
  logic        sysRes = 1'b0;
  logic        start = 1'b0;
  logic [31:0] baseAddr = '0;
  logic [15:0] wordCount = '0;
  logic [31:0] memAddr;
  logic        memRe;
  logic [31:0] memRdata = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] outData;
  logic [31:0] outAddr;
  logic        outLast;
  logic        busy;
  logic        done;
  state_t      fsm_state;

  logic [31:0] ram [0:255];
  beat_t       exp_q[$];

  int checks = 0;
  int errors = 0;
  int re_cnt = 0;
  int done_cnt = 0;
  int hs_cnt = 0;

  logic        stall_chk = 1'b0;
  logic [31:0] held_data, held_addr;
  logic        held_last;

  mem_dump dut (
    .sysClk(sysClk), .sysRes(sysRes), .start(start), .baseAddr(baseAddr),
    .wordCount(wordCount), .memAddr(memAddr), .memRe(memRe), .memRdata(memRdata),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outAddr(outAddr),
    .outLast(outLast), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // Clock/reset
  always #5 sysClk = ~sysClk;

  // Synchronous-read RAM model
  always @(posedge sysClk) begin
    if (memRe) memRdata <= ram[memAddr[9:2]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge sysClk) begin
    if (sysRes) begin
      if (memRe) re_cnt++;
      if (done) done_cnt++;
      if (stall_chk) begin
        chk("stall_valid", 64'(outValid), 64'd1);
        chk("stall_data", 64'(outData), 64'(held_data));
        chk("stall_addr", 64'(outAddr), 64'(held_addr));
        chk("stall_last", 64'(outLast), 64'(held_last));
        if (memRe) chk("stall_memre", 64'(memRe), 64'd0);
      end
      stall_chk = outValid && !outReady;
      held_data = outData;
      held_addr = outAddr;
      held_last = outLast;
      if (outValid && outReady) begin
        beat_t e;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr %0h data %0h, expected no beat", outAddr, outData);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", 64'(outAddr), 64'(e.addr));
          chk("beat_data", 64'(outData), 64'(e.data));
          chk("beat_last", 64'(outLast), 64'(e.last));
        end
      end
    end else begin
      stall_chk = 1'b0;
    end
  end

  // Driver tasks
  task automatic push_dump(input logic [31:0] base, input int count);
    logic [31:0] a;
    logic [31:0] sum;
    a = {base[31:2], 2'b00};
    sum = '0;
    for (int i = 0; i < count; i++) begin
`ifdef MEM_DUMP_CHECKSUM_EN
      exp_q.push_back('{addr: a, data: ram[a[9:2]], last: 1'b0});
`else
      exp_q.push_back('{addr: a, data: ram[a[9:2]], last: (i == count - 1)});
`endif
      sum = sum + ram[a[9:2]];
      a = a + 32'd4;
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    exp_q.push_back('{addr: a, data: sum, last: 1'b1});
`endif
  endtask

  task automatic start_dump(input logic [31:0] base, input logic [15:0] count);
    @(posedge sysClk); #1;
    start = 1'b1;
    baseAddr = base;
    wordCount = count;
    @(posedge sysClk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cycles);
    int d0;
    d0 = done_cnt;
    cycles = 0;
    while (done_cnt == d0 && cycles < 300) begin
      @(posedge sysClk); #1;
      cycles++;
    end
    if (done_cnt == d0) chk({name, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_beat_valid(input int n);
    int t;
    t = 0;
    while (!(outValid && hs_cnt == n) && t < 100) begin
      @(posedge sysClk); #1;
      t++;
    end
    if (!(outValid && hs_cnt == n)) chk("beat_wait_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_clean_dump(input string name, input logic [31:0] base, input int count);
    int d0, r0, cyc;
    d0 = done_cnt;
    r0 = re_cnt;
    push_dump(base, count);
    start_dump(base, 16'(count));
    wait_done(name, cyc);
    repeat (3) @(posedge sysClk);
    #1;
    chk({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({name, "_reads"}, 64'(re_cnt - r0), 64'(count));
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc, h0, d0, r0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h5A000000 + 32'(i);
    ram[8'h40] = 32'h11111111;
    ram[8'h41] = 32'h22222222;
    ram[8'h42] = 32'h33333333;
    ram[8'h43] = 32'h44444444;
    ram[8'hFF] = 32'hDEADBEEF;
    ram[8'h00] = 32'hCAFEF00D;

    // Reset state
    repeat (3) @(posedge sysClk);
    #1;
    chk("rst_memre", 64'(memRe), 64'd0);
    chk("rst_valid", 64'(outValid), 64'd0);
    chk("rst_last", 64'(outLast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_memaddr", 64'(memAddr), 64'd0);
    chk("rst_data", 64'(outData), 64'd0);
    chk("rst_addr", 64'(outAddr), 64'd0);
    sysRes = 1'b1;
    repeat (2) @(posedge sysClk);

    // Basic 4-word dump with latency check
    d0 = done_cnt;
    r0 = re_cnt;
    push_dump(32'h100, 4);
    start_dump(32'h100, 16'd4);
    chk("busy_after_start", 64'(busy), 64'd1);
    @(posedge sysClk); @(negedge sysClk);
    chk("latency_c2", 64'(outValid), 64'd0);
    @(posedge sysClk); @(negedge sysClk);
    chk("latency_c3", 64'(outValid), 64'd1);
    wait_done("basic", cyc);
    repeat (3) @(posedge sysClk);
    #1;
    chk("basic_done_once", 64'(done_cnt - d0), 64'd1);
    chk("basic_reads", 64'(re_cnt - r0), 64'd4);
    chk("basic_drained", 64'(exp_q.size()), 64'd0);

    // Stall 5 cycles during beat 2
    d0 = done_cnt;
    r0 = re_cnt;
    h0 = hs_cnt;
    push_dump(32'h100, 4);
    start_dump(32'h100, 16'd4);
    wait_beat_valid(h0 + 1);
    outReady = 1'b0;
    repeat (5) @(posedge sysClk);
    #1;
    outReady = 1'b1;
    wait_done("stall", cyc);
    repeat (3) @(posedge sysClk);
    #1;
    chk("stall_done_once", 64'(done_cnt - d0), 64'd1);
    chk("stall_reads", 64'(re_cnt - r0), 64'd4);
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Zero-count dump
    d0 = done_cnt;
    r0 = re_cnt;
    h0 = hs_cnt;
    push_dump(32'h200, 0);
    start_dump(32'h200, 16'd0);
    wait_done("zero", cyc);
    chk("zero_done_latency_ok", 64'(cyc <= 2), 64'd1);
    repeat (4) @(posedge sysClk);
    #1;
    chk("zero_reads", 64'(re_cnt - r0), 64'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
    chk("zero_beats", 64'(hs_cnt - h0), 64'd1);
`else
    chk("zero_beats", 64'(hs_cnt - h0), 64'd0);
`endif
    chk("zero_done_once", 64'(done_cnt - d0), 64'd1);

    // Address wrap
    run_clean_dump("wrap", 32'hFFFFFFFC, 2);

    // Unaligned base is treated as aligned
    run_clean_dump("unaligned", 32'h00000107, 2);

    // Reset mid-dump during beat 2
    d0 = done_cnt;
    h0 = hs_cnt;
    push_dump(32'h100, 4);
    start_dump(32'h100, 16'd4);
    wait_beat_valid(h0 + 1);
    outReady = 1'b0;
    @(posedge sysClk); #1;
    sysRes = 1'b0;
    @(posedge sysClk); #1;
    sysRes = 1'b1;
    outReady = 1'b1;
    exp_q.delete();
    @(negedge sysClk);
    chk("abort_valid", 64'(outValid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (12) @(posedge sysClk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_beats", 64'(hs_cnt - h0), 64'd1);

    // Clean dump after abort
    run_clean_dump("post_abort", 32'h100, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
